// File: rtl/arb_pkg.sv
// Shared types for the memory-bus arbiter: FSM states, grant policy, grant index width.
// Imported by the picker and the arbiter top.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  // A single channel still needs a one-bit grant register.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational grant picker: first requester at/after ptr (round-robin) or lowest index (fixed).
// Zero latency; no state, so backpressure is handled entirely by the arbiter FSM.
module rr_picker
  import arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int GW     = grant_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [GW-1:0]     ptr,
  input  arb_mode_t         mode,
  output logic [GW-1:0]     gnt_idx,
  output logic              gnt_vld
);

  int start;
  int idx;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    start   = (mode == ARB_RR) ? int'(ptr) : 0;
    if (start >= NUM_CH) begin
      start = 0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      idx = start + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter onto the single read/write/resp memory bus; grant+request latched in IDLE.
// Latency: request in IDLE -> mem_read/mem_write next cycle; ch_resp combinational with mem_resp.
module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int        NUM_CH   = 2,
  parameter int        ADDR_W   = 32,
  parameter int        DATA_W   = 32,
  parameter arb_mode_t ARB_MODE = ARB_RR
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_read,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*(DATA_W/8)-1:0] ch_byte_enable,
  input  logic [NUM_CH*ADDR_W-1:0]     ch_address,
  input  logic [NUM_CH*DATA_W-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]            ch_resp,
  output logic [DATA_W-1:0]            ch_rdata,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [DATA_W/8-1:0]          mem_byte_enable,
  output logic [ADDR_W-1:0]            mem_address,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_resp,
  output logic                         proto_err
);

  localparam int BE_W = DATA_W / 8;
  localparam int GW   = grant_w(NUM_CH);

  arb_state_t          state_q, state_d;
  logic [GW-1:0]       ptr_q, ptr_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                proto_err_q, proto_err_d;

  logic [GW-1:0]       pick_idx;
  logic                pick_vld;
  logic                done;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .GW     (GW)
  ) u_picker (
    .req     (ch_read | ch_write),
    .ptr     (ptr_q),
    .mode    (ARB_MODE),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign done = (state_q == BUSY) && mem_resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = BUSY;
      BUSY:    if (mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel inputs are sampled only on the IDLE->BUSY edge; BUSY runs purely from these copies.
  always_comb begin
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    proto_err_d = proto_err_q | (|(ch_read & ch_write));
    if ((state_q == IDLE) && pick_vld) begin
      gnt_d   = pick_idx;
      we_d    = ch_write[pick_idx];
      addr_d  = ch_address[int'(pick_idx)*ADDR_W +: ADDR_W];
      be_d    = ch_byte_enable[int'(pick_idx)*BE_W +: BE_W];
      wdata_d = ch_wdata[int'(pick_idx)*DATA_W +: DATA_W];
    end
    if ((ARB_MODE == ARB_RR) && done) begin
      ptr_d = (gnt_q == GW'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      gnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    mem_read        = (state_q == BUSY) && !we_q;
    mem_write       = (state_q == BUSY) && we_q;
    mem_address     = addr_q;
    mem_byte_enable = be_q;
    mem_wdata       = wdata_q;
    proto_err       = proto_err_q;
    ch_resp         = '0;
    if (done) begin
      ch_resp[gnt_q] = 1'b1;
    end
  end

  assign ch_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: a round-robin and a fixed-priority instance share channel stimulus;
// a memory model answers each, and a scoreboard checks every ch_resp against queued expectations.
module tb_mem_arbiter_rr;
  import arb_pkg::*;

  typedef struct {
    int          ch;
    logic        we;
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ch_read, ch_write;
  logic [11:0] ch_byte_enable;
  logic [95:0] ch_address, ch_wdata;

  logic [2:0]  ch_resp_s     [2];
  logic [31:0] ch_rdata_s    [2];
  logic        mem_read_s    [2];
  logic        mem_write_s   [2];
  logic [3:0]  mem_be_s      [2];
  logic [31:0] mem_address_s [2];
  logic [31:0] mem_wdata_s   [2];
  logic [31:0] mem_rdata_s   [2];
  logic        mem_resp_s    [2];
  logic        proto_err_s   [2];

  logic        auto_resp [2];
  int          cnt [2];
  logic        mem_auto;
  logic        man_resp;
  int          wait_cyc;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  assign mem_resp_s[0] = mem_auto ? auto_resp[0] : man_resp;
  assign mem_resp_s[1] = mem_auto ? auto_resp[1] : man_resp;

  mem_arbiter_rr #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .rst(rst_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_byte_enable(ch_byte_enable), .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_resp(ch_resp_s[0]), .ch_rdata(ch_rdata_s[0]), .mem_read(mem_read_s[0]),
    .mem_write(mem_write_s[0]), .mem_byte_enable(mem_be_s[0]), .mem_address(mem_address_s[0]),
    .mem_wdata(mem_wdata_s[0]), .mem_rdata(mem_rdata_s[0]), .mem_resp(mem_resp_s[0]),
    .proto_err(proto_err_s[0])
  );

  mem_arbiter_rr #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .rst(rst_n), .ch_read(ch_read), .ch_write(ch_write),
    .ch_byte_enable(ch_byte_enable), .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_resp(ch_resp_s[1]), .ch_rdata(ch_rdata_s[1]), .mem_read(mem_read_s[1]),
    .mem_write(mem_write_s[1]), .mem_byte_enable(mem_be_s[1]), .mem_address(mem_address_s[1]),
    .mem_wdata(mem_wdata_s[1]), .mem_rdata(mem_rdata_s[1]), .mem_resp(mem_resp_s[1]),
    .proto_err(proto_err_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'hDEAD_BEEF : ~a;
  endfunction

  // Memory model: answers wait_cyc cycles after the request first appears.
  initial begin
    for (int d = 0; d < 2; d++) begin
      auto_resp[d]   = 1'b0;
      cnt[d]         = 0;
      mem_rdata_s[d] = 32'h0BAD_0BAD;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        auto_resp[d]   = 1'b0;
        mem_rdata_s[d] = 32'h0BAD_0BAD;
        if (!rst_n || !mem_auto) begin
          cnt[d] = 0;
        end else if (mem_read_s[d] || mem_write_s[d]) begin
          if (cnt[d] == wait_cyc) begin
            auto_resp[d]   = 1'b1;
            mem_rdata_s[d] = rd_model(mem_address_s[d]);
            cnt[d]         = 0;
          end else begin
            cnt[d]++;
          end
        end
      end
    end
  end

  // Scoreboard: every ch_resp pulse consumes one expected entry for that instance.
  initial begin
    exp_t e;
    logic [2:0] onehot;
    logic       have;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < 2; d++) begin
          if (ch_resp_s[d] != 3'b000) begin
            have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
            if (!have) begin
              n_cmp++;
              n_fail++;
              $display("FAIL unexpected_resp dut%0d: ch_resp=%b, required none", d, ch_resp_s[d]);
            end else begin
              if (d == 0) e = exp_q0.pop_front();
              else        e = exp_q1.pop_front();
              onehot = 3'b001 << e.ch;
              n_cmp++;
              if (ch_resp_s[d] !== onehot) begin
                n_fail++;
                $display("FAIL grant_order dut%0d: ch_resp=%b, required %b", d, ch_resp_s[d], onehot);
              end
              n_cmp++;
              if (mem_address_s[d] !== e.addr || mem_write_s[d] !== e.we) begin
                n_fail++;
                $display("FAIL txn_fields dut%0d: addr=%h we=%b, required addr=%h we=%b",
                         d, mem_address_s[d], mem_write_s[d], e.addr, e.we);
              end
              if (!e.we) begin
                n_cmp++;
                if (ch_rdata_s[d] !== e.rdata) begin
                  n_fail++;
                  $display("FAIL rdata dut%0d: ch_rdata=%h, required %h", d, ch_rdata_s[d], e.rdata);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic push(input int d, input int ch, input logic we, input logic [31:0] addr);
    exp_t e;
    e.ch = ch; e.we = we; e.addr = addr; e.rdata = rd_model(addr);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic set_ch(input int c, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    ch_read[c]                  = rd;
    ch_write[c]                 = wr;
    ch_address[c*32 +: 32]      = addr;
    ch_wdata[c*32 +: 32]        = wdata;
    ch_byte_enable[c*4 +: 4]    = be;
  endtask

  task automatic clear_req();
    ch_read  = '0;
    ch_write = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_req();
    mem_auto = 1'b1;
    man_resp = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (mem_read_s[d] !== 1'b0 || mem_write_s[d] !== 1'b0 || ch_resp_s[d] !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ctrl dut%0d: rd=%b wr=%b resp=%b, required 0 0 000",
                 d, mem_read_s[d], mem_write_s[d], ch_resp_s[d]);
      end
      n_cmp++;
      if (mem_address_s[d] !== 32'h0 || mem_wdata_s[d] !== 32'h0 || mem_be_s[d] !== 4'h0 ||
          proto_err_s[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_data dut%0d: addr=%h wdata=%h be=%h perr=%b, required all 0",
                 d, mem_address_s[d], mem_wdata_s[d], mem_be_s[d], proto_err_s[d]);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    wait_cyc = 3;
    push(0, 1, 1'b0, 32'h40);
    push(1, 1, 1'b0, 32'h40);
    set_ch(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
    @(negedge clk);
    n_cmp++;
    if (mem_read_s[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL read_cycle0: mem_read=%b, required 0", mem_read_s[0]);
    end
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) clear_req();
      @(negedge clk);
      n_cmp++;
      if (mem_read_s[0] !== (c <= 4)) begin
        n_fail++;
        $display("FAIL read_cycle%0d: mem_read=%b, required %b", c, mem_read_s[0], c <= 4);
      end
      if (c == 4) begin
        n_cmp++;
        if (ch_resp_s[0] !== 3'b010 || ch_rdata_s[0] !== 32'hDEAD_BEEF) begin
          n_fail++;
          $display("FAIL read_resp: ch_resp=%b rdata=%h, required 010 deadbeef",
                   ch_resp_s[0], ch_rdata_s[0]);
        end
      end
    end
    @(posedge clk);
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL read_pending: left=%0d/%0d, required 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic run_until_drained(input string name);
    int c;
    c = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && c < 80) begin
      @(posedge clk);
      #1;
      c++;
    end
    clear_req();
    n_cmp++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: left=%0d/%0d, required 0/0", name, exp_q0.size(), exp_q1.size());
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_rr_fairness();
    do_reset();
    wait_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      push(0, k % 3, 1'b0, 32'h1000 + 32'((k % 3) * 16));
      push(1, 0, 1'b0, 32'h1000);
    end
    for (int c = 0; c < 3; c++) set_ch(c, 1'b1, 1'b0, 32'h1000 + 32'(c * 16), 32'h0, 4'hF);
    run_until_drained("rr_fair");
  endtask

  task automatic test_fixed_priority();
    do_reset();
    wait_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      push(0, (k % 2) * 2, 1'b0, (k % 2 == 0) ? 32'h2000 : 32'h2020);
      push(1, 0, 1'b0, 32'h2000);
    end
    set_ch(0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'hF);
    set_ch(2, 1'b1, 1'b0, 32'h2020, 32'h0, 4'hF);
    run_until_drained("fixed");
  endtask

  task automatic test_input_stability();
    int c;
    do_reset();
    wait_cyc = 3;
    push(0, 0, 1'b1, 32'h100);
    push(1, 0, 1'b1, 32'h100);
    set_ch(0, 1'b0, 1'b1, 32'h100, 32'hCAFE_0001, 4'b0011);
    c = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && c < 40) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 2) set_ch(0, 1'b0, 1'b1, 32'h200, 32'h5555_AAAA, 4'b1100);
      @(negedge clk);
      if (mem_write_s[0]) begin
        n_cmp++;
        if (mem_address_s[0] !== 32'h100 || mem_wdata_s[0] !== 32'hCAFE_0001 ||
            mem_be_s[0] !== 4'b0011) begin
          n_fail++;
          $display("FAIL stable_c%0d: addr=%h wdata=%h be=%b, required 100 cafe0001 0011",
                   c, mem_address_s[0], mem_wdata_s[0], mem_be_s[0]);
        end
      end
    end
    run_until_drained("stable");
  endtask

  task automatic test_reset_abort_spurious();
    do_reset();
    mem_auto = 1'b0;
    set_ch(1, 1'b0, 1'b1, 32'h500, 32'h0000_00FF, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_write_s[0] !== 1'b1 || mem_write_s[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy: mem_write=%b/%b, required 1/1", mem_write_s[0], mem_write_s[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_write_s[0] !== 1'b0 || mem_write_s[1] !== 1'b0 ||
        ch_resp_s[0] !== 3'b000 || ch_resp_s[1] !== 3'b000) begin
      n_fail++;
      $display("FAIL abort_drop: mem_write=%b/%b ch_resp=%b/%b, required 0/0 000/000",
               mem_write_s[0], mem_write_s[1], ch_resp_s[0], ch_resp_s[1]);
    end
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    man_resp = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ch_resp_s[0] !== 3'b000 || ch_resp_s[1] !== 3'b000) begin
      n_fail++;
      $display("FAIL spurious_resp: ch_resp=%b/%b, required 000/000", ch_resp_s[0], ch_resp_s[1]);
    end
    @(posedge clk);
    #1;
    man_resp = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mem_read_s[0] || mem_write_s[0] || mem_read_s[1] || mem_write_s[1]) begin
      n_fail++;
      $display("FAIL spurious_state: rd/wr=%b%b/%b%b, required 00/00",
               mem_read_s[0], mem_write_s[0], mem_read_s[1], mem_write_s[1]);
    end
    mem_auto = 1'b1;
  endtask

  task automatic test_proto_err();
    do_reset();
    wait_cyc = 0;
    n_cmp++;
    if (proto_err_s[0] !== 1'b0 || proto_err_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_clear: proto_err=%b/%b, required 0/0", proto_err_s[0], proto_err_s[1]);
    end
    push(0, 0, 1'b1, 32'h300);
    push(1, 0, 1'b1, 32'h300);
    set_ch(0, 1'b1, 1'b1, 32'h300, 32'h1234_5678, 4'hF);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_write_s[0] !== 1'b1 || mem_read_s[0] !== 1'b0 || mem_wdata_s[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL perr_write: wr=%b rd=%b wdata=%h, required 1 0 12345678",
               mem_write_s[0], mem_read_s[0], mem_wdata_s[0]);
    end
    run_until_drained("perr");
    n_cmp++;
    if (proto_err_s[0] !== 1'b1 || proto_err_s[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL perr_sticky: proto_err=%b/%b, required 1/1", proto_err_s[0], proto_err_s[1]);
    end
    do_reset();
    n_cmp++;
    if (proto_err_s[0] !== 1'b0 || proto_err_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL perr_reset: proto_err=%b/%b, required 0/0", proto_err_s[0], proto_err_s[1]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b1;
    mem_auto       = 1'b1;
    man_resp       = 1'b0;
    wait_cyc       = 0;
    ch_read        = '0;
    ch_write       = '0;
    ch_byte_enable = '0;
    ch_address     = '0;
    ch_wdata       = '0;
    #2;
    rst_n = 1'b0;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single_read();
    test_rr_fairness();
    test_fixed_priority();
    test_input_stability();
    test_reset_abort_spurious();
    test_proto_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
